// File: rtl/mem_noc_sram_bridge.sv
// mem_noc_sram_bridge: NoC slave endpoint driving a 1-cycle-latency SRAM.
// A bypassable response FIFO holds read data while the NoC back-pressures.
module mem_noc_sram_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SRAM_AW    = 14,
   parameter int RESP_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_we,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_mask,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic                sram_ce,
   output logic                sram_we,
   output logic [SRAM_AW-1:0]  sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   output logic [DATA_W/8-1:0] sram_wmask,
   input  logic [DATA_W-1:0]   sram_rdata
);
   localparam int HW = ADDR_W - 2;
   localparam int PW = $clog2(RESP_DEPTH);
   localparam int CW = $clog2(RESP_DEPTH + 1);

   logic [HW-1:0]     w_word;
   logic              w_borrow;
   logic              w_in_range;
   logic              w_fire;
   logic              w_empty;
   logic              w_pop;
   logic              w_push;
   logic [CW:0]       w_occ;
   logic [DATA_W-1:0] w_s1_data;

   logic                  r_s1_valid;
   logic                  r_s1_err;
   logic                  r_s1_rd;
   logic [DATA_W-1:0]     r_fifo_data [RESP_DEPTH];
   logic [RESP_DEPTH-1:0] r_fifo_err;
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Word offset from base; the byte-lane borrow keeps modulo-2^ADDR_W math.
   assign w_borrow   = req_addr[1:0] < base_addr[1:0];
   assign w_word     = req_addr[ADDR_W-1:2] - base_addr[ADDR_W-1:2]
                       - HW'(w_borrow);
   assign w_in_range = (w_word >> SRAM_AW) == '0;

   assign w_empty    = (r_count == '0);
   assign w_s1_data  = r_s1_rd ? sram_rdata : '0;
   assign resp_valid = !w_empty || r_s1_valid;
   assign resp_rdata = w_empty ? w_s1_data : r_fifo_data[r_rd_ptr];
   assign resp_err   = w_empty ? (r_s1_valid && r_s1_err)
                               : r_fifo_err[r_rd_ptr];

   assign w_pop  = !w_empty && resp_ready;
   assign w_push = r_s1_valid && (!w_empty || !resp_ready);
   assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_s1_valid};

   assign req_ready = rstn && ((w_occ < (CW+1)'(RESP_DEPTH))
                               || (resp_valid && resp_ready));
   assign w_fire    = req_valid && req_ready;

   assign sram_ce    = w_fire && w_in_range;
   assign sram_we    = req_we;
   assign sram_addr  = w_word[SRAM_AW-1:0];
   assign sram_wdata = req_wdata;
   assign sram_wmask = req_mask;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid <= 1'b0;
         r_s1_err   <= 1'b0;
         r_s1_rd    <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_s1_valid <= w_fire;
         r_s1_err   <= w_fire && !w_in_range;
         r_s1_rd    <= w_fire && w_in_range && !req_we;
         if (w_pop)
            r_rd_ptr <= f_next(r_rd_ptr);
         if (w_push)
            r_wr_ptr <= f_next(r_wr_ptr);
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   // SRAM read data is only valid in S1, so it is captured on push.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= w_s1_data;
         r_fifo_err[r_wr_ptr]  <= r_s1_err;
      end
   end
endmodule

// File: tb/tb_mem_noc_sram_bridge.sv
// tb_mem_noc_sram_bridge: directed plus random traffic against a
// transaction-level scoreboard and a behavioural SRAM.
module tb_mem_noc_sram_bridge;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] base_addr;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_mask;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        sram_ce;
   logic        sram_we;
   logic [13:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_wmask;
   logic [31:0] sram_rdata;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_deliv = 0;
   int          last_tries = 0;
   bit          last_fire = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_d;
   logic        prev_e;
   rsp_t        exp_q [$];
   logic [31:0] ref_mem [0:16383];
   logic [31:0] sram [0:16383];

   always #5 clk = ~clk;

   mem_noc_sram_bridge #(
      .ADDR_W(32), .DATA_W(32), .SRAM_AW(14), .RESP_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn), .base_addr(base_addr),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_we(req_we),
      .req_wdata(req_wdata), .req_mask(req_mask),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
      .sram_rdata(sram_rdata)
   );

   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask[b])
                  sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= sram[sram_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at negedge, update the model, return after posedge.
   task automatic cycle();
      logic [31:0] off;
      bit          inr;
      bit          fire;
      int          idx;
      rsp_t        e;
      @(negedge clk);
      fire = req_valid && req_ready;
      chk("resp_valid", resp_valid, exp_q.size() > 0);
      chk("req_ready", req_ready,
          (exp_q.size() < DEPTH) || (exp_q.size() > 0 && resp_ready));
      off = req_addr - base_addr;
      inr = off < 32'h0001_0000;
      idx = int'(off[15:2]);
      chk("sram_ce", sram_ce, fire && inr);
      if (fire && inr)
         chk("sram_addr", sram_addr, off[15:2]);
      if (prev_stall) begin
         chk("stall_valid", resp_valid, 1'b1);
         chk("stall_rdata", resp_rdata, prev_d);
         chk("stall_err", resp_err, prev_e);
      end
      prev_stall = resp_valid && !resp_ready;
      prev_d = resp_rdata;
      prev_e = resp_err;
      if (resp_valid && resp_ready) begin
         n_deliv++;
         if (exp_q.size() == 0) begin
            chk("spurious_resp", resp_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.d);
            chk("resp_err", resp_err, e.e);
         end
      end
      last_fire = fire;
      if (fire) begin
         if (req_we) begin
            if (inr)
               for (int b = 0; b < 4; b++)
                  if (req_mask[b])
                     ref_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
            e.d = 32'h0;
         end else begin
            e.d = inr ? ref_mem[idx] : 32'h0;
         end
         e.e = !inr;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      req_valid = 1'b1;
      req_we = we;
      req_addr = a;
      req_wdata = d;
      req_mask = m;
      last_tries = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         last_tries++;
         if (last_fire) break;
      end
      if (!last_fire)
         chk("accept_timeout", last_fire, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      req_valid = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++)
         cycle();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int sel;
      rstn = 1'b0;
      base_addr = 32'h8000_0000;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      req_mask = 4'h0;
      resp_ready = 1'b1;
      #2;
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_sram_ce", sram_ce, 1'b0);
      #20 rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1'b1);

      // basic write then read-back
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = 32'h8000_0010;
      req_wdata = 32'hDEAD_BEEF;
      req_mask = 4'hF;
      #1;
      chk("wr_sram_addr", sram_addr, 14'd4);
      chk("wr_sram_ce", sram_ce, 1'b1);
      chk("wr_sram_we", sram_we, 1'b1);
      chk("wr_sram_wmask", sram_wmask, 4'hF);
      issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      chk("wr_lat_valid", resp_valid, 1'b1);
      chk("wr_lat_err", resp_err, 1'b0);
      issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      chk("rd_lat_valid", resp_valid, 1'b1);
      chk("rd_lat_data", resp_rdata, 32'hDEAD_BEEF);
      drain();

      // byte mask merge
      issue(1'b1, 32'h8000_0020, 32'hAAAA_AAAA, 4'hF);
      issue(1'b1, 32'h8000_0020, 32'h1122_3344, 4'b0101);
      issue(1'b0, 32'h8000_0020, 32'h0, 4'h0);
      chk("mask_rdata", resp_rdata, 32'hAA22_AA44);
      drain();

      // out of range, then a normal read
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 32'h8001_0000;
      #1;
      chk("oor_sram_ce", sram_ce, 1'b0);
      issue(1'b0, 32'h8001_0000, 32'h0, 4'h0);
      chk("oor_valid", resp_valid, 1'b1);
      chk("oor_err", resp_err, 1'b1);
      chk("oor_rdata", resp_rdata, 32'h0);
      issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      chk("oor_next_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("oor_next_err", resp_err, 1'b0);
      drain();

      for (int w = 0; w < 16; w++)
         issue(1'b1, 32'h8000_0000 + 32'(4 * w), $urandom, 4'hF);
      drain();

      // back-pressure: A, B accepted, C held off until release
      resp_ready = 1'b0;
      issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
      issue(1'b0, 32'h8000_0008, 32'h0, 4'h0);
      chk("bp_ready_low", req_ready, 1'b0);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 32'h8000_000C;
      for (int i = 0; i < 3; i++)
         cycle();
      chk("bp_c_held", exp_q.size(), 2);
      resp_ready = 1'b1;
      for (int i = 0; i < 10 && !last_fire; i++)
         cycle();
      chk("bp_c_accepted", last_fire, 1'b1);
      drain();

      // throughput: one request and one response per cycle
      n_deliv = 0;
      for (int k = 0; k < 16; k++) begin
         issue(1'b0, 32'h8000_0000 + 32'(4 * k), 32'h0, 4'h0);
         chk("tput_tries", last_tries, 1);
      end
      cycle();
      chk("tput_deliv", n_deliv, 16);
      drain();

      // reset with two responses outstanding
      resp_ready = 1'b0;
      issue(1'b0, 32'h8000_0014, 32'h0, 4'h0);
      issue(1'b0, 32'h8000_0018, 32'h0, 4'h0);
      req_valid = 1'b1;
      req_addr = 32'h8000_001C;
      rstn = 1'b0;
      #1;
      chk("mrst_resp_valid", resp_valid, 1'b0);
      chk("mrst_sram_ce", sram_ce, 1'b0);
      exp_q.delete();
      prev_stall = 1'b0;
      req_valid = 1'b0;
      #20 rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_req_ready", req_ready, 1'b1);
      chk("mrst_valid_after", resp_valid, 1'b0);
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++)
         cycle();

      // randomized traffic on random bases
      for (int r = 0; r < 4; r++) begin
         base_addr = $urandom;
         for (int w = 0; w < 16; w++)
            issue(1'b1, base_addr + 32'(4 * w), $urandom, 4'hF);
         drain();
         for (int i = 0; i < 150; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 7));
            if (sel == 0)
               req_addr = base_addr + 32'h0001_0000
                          + ($urandom_range(0, 255) << 2);
            else if (sel == 1)
               req_addr = base_addr - 32'd4;
            else
               req_addr = base_addr + 4 * $urandom_range(0, 15)
                          + $urandom_range(0, 3);
            req_wdata = $urandom;
            req_mask = 4'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
         end
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_noc_sram_bridge.md
Name: mem_noc_sram_bridge

Overview:
- Slave-side endpoint of the memory NoC. It consumes the request/response channel of one NoC slave port and drives one single-port synchronous SRAM with 1-cycle read latency.
- Translates NoC byte addresses to SRAM word addresses, relative to the slave's base address.
- Flags out-of-range accesses with an error response.
- Buffers responses so the NoC can back-pressure without losing SRAM read data.

Parameters:
- ADDR_W, 32, NoC address width.
- DATA_W, 32, data width; mask width is DATA_W/8.
- SRAM_AW, 14, SRAM word-address width; depth is 2^SRAM_AW words.
- RESP_DEPTH, 2, maximum outstanding responses (in-flight plus buffered); must be at least 2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- base_addr  in  ADDR_W  byte base address of this slave; quasi-static
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_addr  in  ADDR_W  byte address
- req_we  in  1  1=write, 0=read
- req_wdata  in  DATA_W  write data
- req_mask  in  DATA_W/8  byte write enables
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&&ready
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  out-of-range access
- sram_ce  out  1  SRAM chip enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  SRAM_AW  word address
- sram_wdata  out  DATA_W  write data
- sram_wmask  out  DATA_W/8  byte mask
- sram_rdata  in  DATA_W  read data, valid the cycle after a ce&&!we access

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rstn.
- Reset values:
  - s1_valid=0, FIFO empty, count=0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - sram_ce=0.
- Address decode:
  - offset = req_addr - base_addr, computed modulo 2^ADDR_W.
  - in_range = (offset >> 2) < 2^SRAM_AW, i.e. all offset bits above SRAM_AW+1 are zero.
  - sram_addr = offset[SRAM_AW+1:2]. The low 2 address bits are ignored.
- Accept (cycle t):
  - fire = req_valid && req_ready.
  - sram_ce = fire && in_range (combinational).
  - sram_we = req_we; sram_wdata and sram_wmask pass through.
  - An out-of-range access never asserts sram_ce.
- Stage S1 (cycle t+1):
  - s1_valid, s1_we and s1_err are registered from the accept.
  - s1 data = sram_rdata for an in-range read, otherwise 0.
  - s1_err = !in_range.
- Response FIFO: RESP_DEPTH entries of {rdata, err}, FIFO order, no reordering.
- Response output:
  - If the FIFO is non-empty, present the FIFO head.
  - Otherwise, if s1_valid, present S1 directly (bypass).
  - Minimum latency is 1 cycle: resp_valid in cycle t+1.
- S1 not consumed in its cycle: S1 is pushed into the FIFO at the end of that cycle. S1 is pushed whenever the FIFO is non-empty or resp_ready is 0.
- Occupancy and ready:
  - occ = fifo_count + s1_valid.
  - req_ready = (occ < RESP_DEPTH) || (resp_valid && resp_ready).
  - Steady-state throughput is 1 request/cycle when resp_ready=1.
- Simultaneous pop and push: the FIFO head is popped and S1 is pushed in the same cycle; count is unchanged.
- Write semantics: every write returns exactly one response (rdata=0, err=0 or 1). SRAM write takes effect in cycle t.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data (SRAM write-first timing).
- Stall: resp_valid, resp_rdata and resp_err stay stable while resp_valid && !resp_ready.
- Reset mid-operation: all outstanding responses are dropped and sram_ce drops immediately. Issuing masters must also be reset.
- Response count invariant: accepted requests minus delivered responses never exceeds RESP_DEPTH.

Test Plan:
- Basic write/read: base_addr=0x8000_0000; write 0xDEADBEEF, mask 4'hF, to 0x8000_0010 -> sram_addr=4, response err=0 at t+1. Then read 0x8000_0010 -> resp_rdata=0xDEADBEEF at t+1.
- Byte mask: write 0x11223344, mask 4'b0101, over stored 0xAAAAAAAA -> subsequent read returns 0xAA22AA44.
- Out of range: read 0x8001_0000 with SRAM_AW=14 -> sram_ce stays 0, resp_err=1, resp_rdata=0. Next in-range read completes normally.
- Back-pressure: hold resp_ready=0 and issue reads A, B, C back-to-back -> A and B accepted, req_ready=0 from cycle t+2. Release resp_ready -> A, B, C delivered in order with correct data and no drops.
- Throughput: 16 consecutive reads with resp_ready=1 -> req_ready is never deasserted, and 16 responses arrive on 16 consecutive cycles starting at t+1.
- Reset: assert rstn low with 2 responses buffered -> resp_valid=0 and req_ready=1 after release; no stale response appears.
